// File: rtl/fabric_irq_ctrl.sv
// APB-mapped aggregator: synchronises, latches, masks and prioritises fabric interrupt sources.
// Optional soft-trigger register at 0x18 when FABRIC_IRQ_CTRL_SOFT_TRIG_EN is defined.
module fabric_irq_ctrl #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               PCLK,
    input  logic               PRESETN,
    input  logic [8:0]         PADDR,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [7:0]         PWDATA,
    output logic [7:0]         PRDATA,
    input  logic [NUM_IRQ-1:0] IRQ_IN,
    output logic               IRQ_OUT
);

    localparam int unsigned DW = 8;

    localparam logic [2:0] A_PEND   = 3'd0;
    localparam logic [2:0] A_ENABLE = 3'd1;
    localparam logic [2:0] A_MODE   = 3'd2;
    localparam logic [2:0] A_CLEAR  = 3'd3;
    localparam logic [2:0] A_RAW    = 3'd4;
    localparam logic [2:0] A_ID     = 3'd5;
`ifdef FABRIC_IRQ_CTRL_SOFT_TRIG_EN
    localparam logic [2:0] A_SWTRIG = 3'd6;
`endif

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] sync_c;
    logic [NUM_IRQ-1:0] sync_d_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [DW-1:0]      prdata_q, prdata_d;
    logic               irq_q, irq_d;

    logic               addr_ok_c;
    logic [2:0]         reg_idx_c;
    logic               wr_c;
    logic               rd_c;
    logic [NUM_IRQ-1:0] wdata_c;
    logic [NUM_IRQ-1:0] clr_c;
    logic [NUM_IRQ-1:0] mode_chg_c;
    logic [NUM_IRQ-1:0] edge_set_c;
    logic [NUM_IRQ-1:0] act_c;
    logic [DW-1:0]      id_c;
    logic [DW-1:0]      rdata_c;
    logic               found_c;
    logic               unused_c;

    // Byte-lane bits of the address carry no meaning in this map
    assign unused_c  = ^{PADDR[1:0], PWDATA};

    assign sync_c    = sync_q[SYNC_STAGES-1];
    assign addr_ok_c = (PADDR[8:5] == 4'd0);
    assign reg_idx_c = PADDR[4:2];
    assign wr_c      = PSEL & PENABLE & PWRITE & addr_ok_c;
    assign rd_c      = PSEL & ~PENABLE & ~PWRITE;
    assign wdata_c   = PWDATA[NUM_IRQ-1:0];
    assign act_c     = pend_q & en_q;

    // Register writes and per-source pending update
    always_comb begin
        en_d       = en_q;
        mode_d     = mode_q;
        clr_c      = '0;
        mode_chg_c = '0;
        edge_set_c = sync_c & ~sync_d_q;
        if (wr_c) begin
            case (reg_idx_c)
                A_ENABLE: en_d = wdata_c;
                A_MODE: begin
                    mode_d     = wdata_c;
                    mode_chg_c = mode_q ^ wdata_c;
                end
                A_CLEAR:  clr_c = wdata_c;
`ifdef FABRIC_IRQ_CTRL_SOFT_TRIG_EN
                A_SWTRIG: edge_set_c = edge_set_c | wdata_c;
`endif
                default: ;
            endcase
        end
        // Set sources are ORed after the clear so a coincident edge wins
        pend_d = (mode_q & ((pend_q & ~clr_c) | edge_set_c)) | (~mode_q & sync_c);
        pend_d = pend_d & ~mode_chg_c;
        irq_d  = |act_c;
    end

    // Lowest-index active source, 0xFF when none
    always_comb begin
        id_c    = 8'hFF;
        found_c = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (act_c[i] && !found_c) begin
                id_c    = 8'(i);
                found_c = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        if (addr_ok_c) begin
            case (reg_idx_c)
                A_PEND:   rdata_c = DW'(pend_q);
                A_ENABLE: rdata_c = DW'(en_q);
                A_MODE:   rdata_c = DW'(mode_q);
                A_RAW:    rdata_c = DW'(sync_c);
                A_ID:     rdata_c = id_c;
                default:  rdata_c = '0;
            endcase
        end
        prdata_d = rd_c ? rdata_c : prdata_q;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sync_q   <= '0;
            sync_d_q <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            prdata_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], IRQ_IN};
            sync_d_q <= sync_c;
            pend_q   <= pend_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            prdata_q <= prdata_d;
            irq_q    <= irq_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign IRQ_OUT = irq_q;

endmodule

// File: tb/tb_fabric_irq_ctrl.sv
// Scoreboard bench for fabric_irq_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_fabric_irq_ctrl;

    logic       PCLK;
    logic       PRESETN;
    logic [8:0] PADDR;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic [7:0] IRQ_IN;
    logic       IRQ_OUT;

    fabric_irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .IRQ_IN  (IRQ_IN),
        .IRQ_OUT (IRQ_OUT)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  rd_v[$];
    string       rd_n[$];
    logic [7:0]  ob_v[$];
    string       ob_n[$];
    bit          obs_en  = 1'b0;
    bit          obs_sel = 1'b0;
    bit          done    = 1'b0;
    bit          fin_done = 1'b0;

    // Monitor: read data in every read access phase, and explicit observation points
    always @(negedge PCLK) begin
        logic [7:0] e;
        logic [7:0] a;
        string      n;
        if (PRESETN && PSEL && PENABLE && !PWRITE) begin
            total++;
            if (rd_v.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got %02h want none", PRDATA);
            end else begin
                e = rd_v.pop_front();
                n = rd_n.pop_front();
                if (PRDATA !== e) begin
                    bad++;
                    $display("FAIL %s: got %02h want %02h", n, PRDATA, e);
                end
            end
        end
        if (obs_en) begin
            total++;
            a = obs_sel ? PRDATA : {7'd0, IRQ_OUT};
            if (ob_v.size() == 0) begin
                bad++;
                $display("FAIL obs_unexpected: got %02h want none", a);
            end else begin
                e = ob_v.pop_front();
                n = ob_n.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got %02h want %02h", n, a, e);
                end
            end
        end
        if (done && !fin_done) begin
            total++;
            if (rd_v.size() != 0 || ob_v.size() != 0) begin
                bad++;
                $display("FAIL leftover: got %0d pending want 0", rd_v.size() + ob_v.size());
            end
            fin_done = 1'b1;
        end
    end

    task automatic tick;
        @(posedge PCLK);
        #1;
        obs_en = 1'b0;
    endtask

    // sel 0 checks IRQ_OUT, sel 1 checks PRDATA, at this cycle's negedge
    task automatic obs(input bit sel, input logic [7:0] exp, input string name);
        ob_v.push_back(exp);
        ob_n.push_back(name);
        obs_sel = sel;
        obs_en  = 1'b1;
    endtask

    task automatic apb_wr(input logic [8:0] addr, input logic [7:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        tick;
        PENABLE = 1'b1;
        tick;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [8:0] addr, input logic [7:0] exp, input string name);
        rd_v.push_back(exp);
        rd_n.push_back(name);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        tick;
        PENABLE = 1'b1;
        tick;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sw_exp;
        PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; IRQ_IN = 8'hFF;

        // Reset held with all sources asserted
        tick; tick;
        obs(1'b0, 8'h00, "rst_irq");
        tick;
        obs(1'b1, 8'h00, "rst_prdata");
        tick;
        IRQ_IN = 8'h00;
        tick; tick;
        PRESETN = 1'b1;
        tick;
        apb_rd(9'h000, 8'h00, "rst_pend");
        apb_rd(9'h004, 8'h00, "rst_enable");
        apb_rd(9'h008, 8'h00, "rst_mode");
        apb_rd(9'h014, 8'hFF, "rst_id");
        apb_rd(9'h018, 8'h00, "rst_swtrig_rd");

        // Level path, 4-cycle latency each way
        apb_wr(9'h004, 8'h01);
        IRQ_IN = 8'h01;
        repeat (3) tick;
        obs(1'b0, 8'h00, "lvl_rise_early");
        tick;
        obs(1'b0, 8'h01, "lvl_rise_4cyc");
        apb_rd(9'h010, 8'h01, "lvl_raw");
        apb_rd(9'h000, 8'h01, "lvl_pend");
        apb_rd(9'h014, 8'h00, "lvl_id");
        apb_wr(9'h00C, 8'h01);
        apb_rd(9'h000, 8'h01, "lvl_clear_noeffect");
        obs(1'b0, 8'h01, "lvl_irq_after_clear");
        apb_wr(9'h024, 8'hFF);
        apb_rd(9'h007, 8'h01, "unmapped_wr_ignored");
        apb_rd(9'h020, 8'h00, "unmapped_rd");
        IRQ_IN = 8'h00;
        repeat (3) tick;
        obs(1'b0, 8'h01, "lvl_fall_early");
        tick;
        obs(1'b0, 8'h00, "lvl_fall_4cyc");

        // Edge latch and clear
        apb_wr(9'h008, 8'h08);
        apb_wr(9'h004, 8'h08);
        IRQ_IN = 8'h08;
        repeat (3) tick;
        IRQ_IN = 8'h00;
        repeat (4) tick;
        apb_rd(9'h000, 8'h08, "edge_pend_held");
        apb_rd(9'h014, 8'h03, "edge_id");
        obs(1'b0, 8'h01, "edge_irq");
        apb_wr(9'h00C, 8'h08);
        obs(1'b0, 8'h01, "clr_irq_t1");
        tick;
        obs(1'b0, 8'h00, "clr_irq_t2");
        apb_rd(9'h000, 8'h00, "clr_pend");

        // Rising edge of bit 2 coincides with the CLEAR commit edge
        apb_wr(9'h008, 8'h0C);
        IRQ_IN = 8'h04;
        tick;
        apb_wr(9'h00C, 8'h04);
        apb_rd(9'h000, 8'h04, "collide_pend");
        obs(1'b0, 8'h00, "collide_masked_irq");
        IRQ_IN = 8'h00;
        apb_rd(9'h014, 8'hFF, "collide_id_masked");

        // Priority and mask
        apb_wr(9'h00C, 8'h04);
        apb_wr(9'h008, 8'h0A);
        IRQ_IN = 8'h0A;
        repeat (2) tick;
        IRQ_IN = 8'h00;
        repeat (4) tick;
        apb_rd(9'h000, 8'h0A, "prio_pend");
        apb_rd(9'h014, 8'h03, "prio_id_mask");
        apb_wr(9'h004, 8'h0A);
        apb_rd(9'h014, 8'h01, "prio_id_both");
        obs(1'b0, 8'h01, "prio_irq_on");
        apb_wr(9'h004, 8'h00);
        apb_rd(9'h014, 8'hFF, "prio_id_none");
        obs(1'b0, 8'h00, "prio_irq_off");
        apb_rd(9'h000, 8'h0A, "prio_pend_kept");
        apb_wr(9'h008, 8'h08);
        apb_rd(9'h000, 8'h08, "mode_chg_clr");

        // Soft trigger: only edge-mode bits may be set
`ifdef FABRIC_IRQ_CTRL_SOFT_TRIG_EN
        sw_exp = 8'h80;
`else
        sw_exp = 8'h00;
`endif
        apb_wr(9'h008, 8'h80);
        apb_rd(9'h000, 8'h00, "swtrig_pre_pend");
        apb_wr(9'h018, 8'h81);
        apb_rd(9'h000, sw_exp, "swtrig_pend");
        apb_rd(9'h018, 8'h00, "swtrig_read");

        done = 1'b1;
        tick; tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fabric_irq_ctrl.md
# fabric_irq_ctrl

APB-mapped interrupt aggregator that collects level interrupts from fabric peripherals, including the CoreI2C `INT` output, and presents one registered interrupt request to the MSS fabric interrupt input. It sits directly downstream of the I2C wrapper, on the same APB bus and `PCLK` domain. It synchronises, latches, masks and prioritises up to 8 sources so the MSS handler reads one ID register instead of polling each core.

## Interface
- `NUM_IRQ`, 8: number of sources, 1..8.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..3.
- `PCLK` in 1: the single clock.
- `PRESETN` in 1: reset, asynchronous assert, active-low. One clock, `PCLK`; reset is asynchronous and active-low.
- `PADDR` in 9: byte address.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB access phase.
- `PWRITE` in 1: 1 = write.
- `PWDATA` in 8: write data.
- `PRDATA` out 8: read data.
- `IRQ_IN` in `NUM_IRQ`: source interrupts, active-high, asynchronous to `PCLK`.
- `IRQ_OUT` out 1: aggregated request to the MSS, active-high, registered.

## Operation
- **APB transfers**
  - No wait states.
  - A write commits on the cycle where `PSEL & PENABLE & PWRITE` are all high.
  - A read is sampled into `PRDATA` on the setup cycle (`PSEL & ~PENABLE & ~PWRITE`) and held through the access phase.
- **Address decode**
  - `PADDR[8:5]` must be 0 and `PADDR[1:0]` are ignored; otherwise the address is unmapped.
  - Unmapped reads return 0x00. Unmapped writes are ignored.
  - Bits at index `NUM_IRQ` and above read 0 and are write-ignored.
- **Register map**
  - 0x00 `PEND` (RO): pending bits.
  - 0x04 `ENABLE` (RW): mask; 1 = enabled.
  - 0x08 `MODE` (RW): 1 = edge latch, 0 = level.
  - 0x0C `CLEAR` (W1C): clears edge-mode pending bits; reads 0.
  - 0x10 `RAW` (RO): synchronised inputs.
  - 0x14 `ID` (RO): lowest index with `PEND & ENABLE` set; 0xFF if none.
- **Pending logic, per source i, evaluated each cycle**
  - Level mode: `PEND[i]` = `sync[i]`. `CLEAR` has no effect.
  - Edge mode: `PEND[i]` is set on a synchronised rising edge (`sync[i] & ~sync_d[i]`). It stays set until a `CLEAR` write with bit i = 1.
  - A rising edge in the same cycle as a clear of the same bit: the edge wins and the bit stays 1.
  - Writing `MODE` clears `PEND[i]` for every bit whose mode changes. A bit that changes to level mode then follows `sync` from the next cycle.
- **Output**
  - `IRQ_OUT` <= |(`PEND & ENABLE`), registered.
  - Disabling a source removes its contribution on the next `IRQ_OUT` update. Its `PEND` bit is not cleared.
- **Reset values**
  - On `PRESETN` low, all synchroniser flops, `sync_d`, `PEND`, `ENABLE`, `MODE`, `PRDATA` and `IRQ_OUT` go to 0.
  - This holds even mid-transfer; a transfer interrupted by reset has no effect.

## Timing
- Latency from an `IRQ_IN` rise to `IRQ_OUT` high is `SYNC_STAGES` + 2 `PCLK` cycles, with the source already enabled:
  - `SYNC_STAGES` cycles through the synchroniser;
  - 1 cycle to update `PEND`;
  - 1 cycle to register `IRQ_OUT`.
- A write to `CLEAR`, `ENABLE` or `MODE` in access cycle T updates the register at the edge ending T. `IRQ_OUT` reflects it one edge later (T+2).
- `ID` and `PEND` are read as sampled at the setup-cycle edge.
- Edge mode requires an input to be low for at least 1 `PCLK` cycle after synchronisation before it can re-trigger. Shorter pulses may be missed; this is documented, not detected.

## Configuration
- `FABRIC_IRQ_CTRL_SOFT_TRIG_EN` defined:
  - Adds 0x18 `SWTRIG` (WO, reads 0).
  - Writing 1 to bit i sets `PEND[i]` in the commit cycle, but only for edge-mode bits. Level-mode bits ignore it.
  - If the same bit is written in `SWTRIG` and `CLEAR` in one transfer, set wins (it cannot happen in one transfer, but it can across back-to-back cycles, which are resolved in order).
- `FABRIC_IRQ_CTRL_SOFT_TRIG_EN` undefined:
  - 0x18 is unmapped: reads 0x00, writes ignored.
  - No soft-trigger logic is synthesised.

## Test plan
- **Reset:** hold `PRESETN` low with `IRQ_IN`=0xFF. Required: `IRQ_OUT`=0 and `PRDATA`=0. After release, reads of 0x00, 0x04 and 0x08 return 0x00, and 0x14 returns 0xFF.
- **Level path:** `ENABLE`=0x01, `MODE`=0x00, raise `IRQ_IN[0]`. Required: `IRQ_OUT` high exactly 4 cycles later (`SYNC_STAGES`=2). Lower the input: `IRQ_OUT` low 4 cycles later. `CLEAR` 0x01 while the input is high has no effect.
- **Edge latch and clear:** `MODE`=0x08, `ENABLE`=0x08, pulse `IRQ_IN[3]` for 3 cycles. Required: `PEND`=0x08 is held after the pulse and `ID`=0x03. Write `CLEAR` 0x08: `PEND`=0x00 and `IRQ_OUT` low 2 cycles after the access cycle.
- **Clear collision:** in edge mode, time a synchronised rising edge of bit 2 to coincide with the `CLEAR` 0x04 commit. Required: `PEND[2]` remains 1.
- **Priority and mask:** `PEND`=0x0A with `ENABLE`=0x08. Required: `ID`=0x03. Then set `ENABLE`=0x0A: `ID`=0x01. Then set `ENABLE`=0x00: `ID`=0xFF and `IRQ_OUT`=0.
- **Soft trigger:** with `FABRIC_IRQ_CTRL_SOFT_TRIG_EN` defined, write `SWTRIG` 0x81 with `MODE`=0x80. Required: `PEND`=0x80; bit 0 is not set because it is in level mode. With the macro undefined, the same write leaves `PEND`=0x00 and 0x18 reads 0x00.
